// File: rtl/receiving.sv
// UART-style receiver: 16x oversampled, 2-flop input synchronizer, mid-bit sampling.
// Reports good characters, sticky framing/overrun errors, and handles read handshakes.
module receiving #(
    parameter int unsigned SAMPLES_PER_BIT = 16,
    parameter int unsigned SAMPLE_POINT    = 7,
    parameter int unsigned DATA_BITS       = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 r_enable,
    input  logic                 serial_in,
    input  logic                 read_ack,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    output logic                 char_received,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int unsigned BIT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [3:0]       LAST_SAMPLE = 4'(SAMPLES_PER_BIT - 1);
    localparam logic [3:0]       MID_SAMPLE  = 4'(SAMPLE_POINT);
    localparam logic [BIT_W-1:0] LAST_BIT    = BIT_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_DATA      = 3'd2,
        S_STOP      = 3'd3,
        S_WAIT_IDLE = 3'd4
    } state_t;

    state_t               r_state;
    state_t               w_state_n;
    logic                 r_sync1;
    logic                 r_sync2;
    logic [3:0]           r_sample;
    logic [3:0]           w_sample_n;
    logic [BIT_W-1:0]     r_bit;
    logic [BIT_W-1:0]     w_bit_n;
    logic [DATA_BITS-1:0] r_shift;
    logic [DATA_BITS-1:0] w_shift_n;
    logic                 w_rx;
    logic                 w_mid;
    logic                 w_wrap;
    logic [3:0]           w_sample_inc;
    logic                 w_good;
    logic                 w_ferr;

    assign w_rx         = r_sync2;
    assign w_mid        = (r_sample == MID_SAMPLE);
    assign w_wrap       = (r_sample == LAST_SAMPLE);
    assign w_sample_inc = w_wrap ? '0 : r_sample + 4'd1;
    assign busy         = (r_state != S_IDLE);

    always_comb begin
        w_state_n  = r_state;
        w_sample_n = r_sample;
        w_bit_n    = r_bit;
        w_shift_n  = r_shift;
        w_good     = 1'b0;
        w_ferr     = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_sample_n = '0;
                w_bit_n    = '0;
                if (!w_rx && r_enable) w_state_n = S_START;
            end
            S_START: begin
                w_sample_n = w_sample_inc;
                if (w_mid && w_rx) begin
                    w_state_n  = S_IDLE;
                    w_sample_n = '0;
                end else if (w_wrap) begin
                    w_state_n = S_DATA;
                    w_bit_n   = '0;
                end
            end
            S_DATA: begin
                w_sample_n = w_sample_inc;
                if (w_mid) w_shift_n = {w_rx, r_shift[DATA_BITS-1:1]};
                if (w_wrap) begin
                    if (r_bit == LAST_BIT) w_state_n = S_STOP;
                    else                   w_bit_n   = r_bit + 1'b1;
                end
            end
            S_STOP: begin
                w_sample_n = w_sample_inc;
                // Leaving at the stop mid-bit lets an immediately following start edge be caught.
                if (w_mid) begin
                    w_sample_n = '0;
                    if (w_rx) begin
                        w_good    = 1'b1;
                        w_state_n = S_IDLE;
                    end else begin
                        w_ferr    = 1'b1;
                        w_state_n = S_WAIT_IDLE;
                    end
                end
            end
            S_WAIT_IDLE: begin
                w_sample_n = '0;
                if (w_rx) w_state_n = S_IDLE;
            end
            default: begin
                w_state_n  = S_IDLE;
                w_sample_n = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1       <= 1'b1;
            r_sync2       <= 1'b1;
            r_state       <= S_IDLE;
            r_sample      <= '0;
            r_bit         <= '0;
            r_shift       <= '0;
            data_out      <= '0;
            data_valid    <= 1'b0;
            char_received <= 1'b0;
            frame_err     <= 1'b0;
            overrun       <= 1'b0;
        end else begin
            r_sync1       <= serial_in;
            r_sync2       <= r_sync1;
            r_state       <= w_state_n;
            r_sample      <= w_sample_n;
            r_bit         <= w_bit_n;
            r_shift       <= w_shift_n;
            char_received <= w_good;
            if (w_good) data_out <= r_shift;
            // A new character wins over a same-edge acknowledge; overrun only without that ack.
            data_valid    <= w_good | (data_valid & ~read_ack);
            overrun       <= (w_good & data_valid & ~read_ack) | (overrun & ~read_ack);
            frame_err     <= w_ferr | (frame_err & ~read_ack);
        end
    end

endmodule

// File: tb/tb_receiving.sv
// Directed bench for receiving: scoreboard of expected characters popped on each
// char_received pulse, plus timing, error-flag and handshake checks.
module tb_receiving;

    logic       clk = 1'b0;
    logic       reset;
    logic       r_enable;
    logic       serial_in;
    logic       read_ack;
    logic [7:0] data_out;
    logic       data_valid;
    logic       char_received;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int n_pulses = 0;
    int last_char_cyc = 0;
    logic [31:0] exp_q[$];

    receiving #(.SAMPLES_PER_BIT(16), .SAMPLE_POINT(7), .DATA_BITS(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .r_enable     (r_enable),
        .serial_in    (serial_in),
        .read_ack     (read_ack),
        .data_out     (data_out),
        .data_valid   (data_valid),
        .char_received(char_received),
        .frame_err    (frame_err),
        .overrun      (overrun),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every character pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (char_received === 1'b1) begin
            logic [31:0] e;
            n_pulses++;
            last_char_cyc = cyc;
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
            check("char", 32'(data_out), e);
        end
    end

    // Drives a frame (start, 8 data LSB first, stop) for up to ncyc cycles;
    // read_ack is raised for the single cycle with index ack_at.
    task automatic send(input logic [7:0] b, input logic stopb, input int ack_at, input int ncyc);
        logic [9:0] fb;
        int k;
        fb = {stopb, b, 1'b0};
        k  = 0;
        for (int bi = 0; bi < 10; bi++) begin
            for (int s = 0; s < 16; s++) begin
                if (k < ncyc) begin
                    serial_in = fb[0];
                    read_ack  = (k == ack_at);
                    @(negedge clk);
                    k++;
                end
            end
            fb = fb >> 1;
        end
        read_ack = 1'b0;
    endtask

    task automatic ack_pulse();
        read_ack = 1'b1;
        @(negedge clk);
        read_ack = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int c0;
        int p0;
        int busy_cnt;

        reset = 1'b1; r_enable = 1'b1; serial_in = 1'b1; read_ack = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_flags", 32'({data_valid, char_received, frame_err, overrun, busy}), 32'h0);
        check("reset_data", 32'(data_out), 32'h0);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check("idle_busy", 32'(busy), 32'h0);
        check("idle_valid", 32'(data_valid), 32'h0);

        // 0xA5 with latency measurement from the pin edge
        exp_q.push_back(32'hA5);
        p0 = n_pulses;
        c0 = cyc;
        send(8'hA5, 1'b1, -1, 160);
        repeat (2) @(negedge clk);
        check("a5_pulses", 32'(n_pulses - p0), 32'd1);
        check("a5_latency", 32'(last_char_cyc - c0), 32'd155);
        check("a5_valid", 32'(data_valid), 32'h1);
        check("a5_ferr", 32'(frame_err), 32'h0);
        check("a5_data", 32'(data_out), 32'hA5);
        ack_pulse();
        check("a5_ack_valid", 32'(data_valid), 32'h0);

        // 4-cycle low glitch: false start rejected at the mid-bit
        p0 = n_pulses;
        busy_cnt = 0;
        serial_in = 1'b0;
        for (int i = 0; i < 34; i++) begin
            if (i == 4) serial_in = 1'b1;
            @(negedge clk);
            if (busy === 1'b1) busy_cnt++;
        end
        check("glitch_busy_cycles", 32'(busy_cnt), 32'd8);
        check("glitch_pulses", 32'(n_pulses - p0), 32'd0);
        check("glitch_valid", 32'(data_valid), 32'h0);
        check("glitch_data", 32'(data_out), 32'hA5);

        // r_enable low gates start detection
        r_enable = 1'b0;
        busy_cnt = 0;
        serial_in = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (busy === 1'b1) busy_cnt++;
        end
        serial_in = 1'b1;
        repeat (4) @(negedge clk);
        r_enable = 1'b1;
        check("disabled_busy_cycles", 32'(busy_cnt), 32'd0);

        // 0x3C with stop bit 0 and a held-low line
        exp_q.push_back(32'hC3);
        send(8'hC3, 1'b1, -1, 160);
        repeat (2) @(negedge clk);
        p0 = n_pulses;
        send(8'h3C, 1'b0, -1, 160);
        serial_in = 1'b0;
        repeat (40) @(negedge clk);
        check("ferr_set", 32'(frame_err), 32'h1);
        check("ferr_valid_kept", 32'(data_valid), 32'h1);
        check("ferr_data_kept", 32'(data_out), 32'hC3);
        check("ferr_pulses", 32'(n_pulses - p0), 32'd0);
        check("ferr_busy_low_line", 32'(busy), 32'h1);
        serial_in = 1'b1;
        repeat (2) @(negedge clk);
        check("ferr_busy_before_rise", 32'(busy), 32'h1);
        @(negedge clk);
        check("ferr_idle_after_rise", 32'(busy), 32'h0);
        ack_pulse();
        check("ferr_ack_valid", 32'(data_valid), 32'h0);
        check("ferr_ack_clear", 32'(frame_err), 32'h0);

        // back-to-back 0x11, 0x22 without acknowledge
        exp_q.push_back(32'h11);
        exp_q.push_back(32'h22);
        send(8'h11, 1'b1, -1, 160);
        send(8'h22, 1'b1, -1, 160);
        repeat (2) @(negedge clk);
        check("ovr_data", 32'(data_out), 32'h22);
        check("ovr_flag", 32'(overrun), 32'h1);
        check("ovr_valid", 32'(data_valid), 32'h1);
        ack_pulse();
        check("ovr_ack_valid", 32'(data_valid), 32'h0);
        check("ovr_ack_flag", 32'(overrun), 32'h0);

        // reset during data bit 4 of 0x5A, then 0x81
        p0 = n_pulses;
        send(8'h5A, 1'b1, -1, 88);
        check("mid_frame_busy", 32'(busy), 32'h1);
        reset = 1'b1;
        serial_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_flags", 32'({data_valid, char_received, frame_err, overrun, busy}), 32'h0);
            check("rst_data", 32'(data_out), 32'h0);
        end
        reset = 1'b0;
        repeat (2) @(negedge clk);
        exp_q.push_back(32'h81);
        send(8'h81, 1'b1, -1, 160);
        repeat (2) @(negedge clk);
        check("post_rst_pulses", 32'(n_pulses - p0), 32'd1);
        check("post_rst_data", 32'(data_out), 32'h81);
        ack_pulse();

        // acknowledge on the edge the second character lands
        exp_q.push_back(32'h01);
        exp_q.push_back(32'h02);
        send(8'h01, 1'b1, -1, 160);
        send(8'h02, 1'b1, 154, 160);
        repeat (2) @(negedge clk);
        check("ackedge_data", 32'(data_out), 32'h02);
        check("ackedge_valid", 32'(data_valid), 32'h1);
        check("ackedge_overrun", 32'(overrun), 32'h0);

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/receiving.md
RECEIVING -- requirements
Module: receiving

Interface
REQ-001 Parameter SAMPLES_PER_BIT, default 16: clk cycles per serial bit; the value is fixed at 16 and matches the transmit side.
REQ-002 Parameter SAMPLE_POINT, default 7: sample counter value at which a bit is evaluated (mid-bit).
REQ-003 Parameter DATA_BITS, default 8: payload bits per frame.
REQ-004 clk  in  1  single clock, 16x bit rate; all logic on rising edge; one clock, no other clock domains.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 r_enable  in  1  permits detection of a new start bit; does not abort a frame in progress.
REQ-007 serial_in  in  1  asynchronous serial line; idle high.
REQ-008 read_ack  in  1  consumer has taken data_out; clears data_valid.
REQ-009 data_out  out  DATA_BITS  last good received character.
REQ-010 data_valid  out  1  data_out holds an unread character.
REQ-011 char_received  out  1  one-cycle pulse per good character.
REQ-012 frame_err  out  1  sticky; last frame had stop bit = 0.
REQ-013 overrun  out  1  sticky; a good character overwrote an unread one.
REQ-014 busy  out  1  high in any state other than IDLE.

Function
REQ-015 Frame format: start bit 0, DATA_BITS data bits LSB first, stop bit 1; 10 bits total at the default DATA_BITS.
REQ-016 serial_in passes through a 2-flop synchronizer (sync_rx); all decisions use sync_rx only; pin-to-sync_rx latency is 2 cycles.
REQ-017 States: IDLE, START, DATA, STOP, WAIT_IDLE; a 4-bit sample_cnt and a bit counter (0..DATA_BITS-1) drive all transitions.
REQ-018 IDLE: on sync_rx=0 with r_enable=1 -> START, sample_cnt=0; call this edge E0; with r_enable=0 stay IDLE.
REQ-019 sample_cnt increments every cycle outside IDLE/WAIT_IDLE and wraps 15->0; each wrap ends one bit period.
REQ-020 START at sample_cnt=SAMPLE_POINT: sync_rx=1 -> IDLE (false start, no flags change); sync_rx=0 -> continue; on wrap -> DATA, bit counter 0.
REQ-021 DATA at sample_cnt=SAMPLE_POINT: shift register shifts right, sync_rx enters MSB; bit k is sampled at edge E0+16(k+1)+7; after the wrap of bit DATA_BITS-1 -> STOP.
REQ-022 STOP at sample_cnt=SAMPLE_POINT (edge E0+151 at defaults), sync_rx=1: data_out<=shift register, data_valid<=1, char_received=1 for the following cycle, -> IDLE.
REQ-023 STOP at sample_cnt=SAMPLE_POINT, sync_rx=0: frame_err<=1, data_out/data_valid unchanged, no char_received, -> WAIT_IDLE.
REQ-024 WAIT_IDLE: remain until sync_rx=1, then -> IDLE; a low line (break) therefore never restarts reception.
REQ-025 read_ack with data_valid=1: data_valid, frame_err and overrun clear on the next edge; read_ack with data_valid=0 clears frame_err and overrun only.
REQ-026 A good character completing while data_valid=1 and read_ack=0: data_out is overwritten, data_valid stays 1, overrun<=1.
REQ-027 A good character completing in the same cycle as read_ack: the new character loads, data_valid stays 1, overrun not set; frame_err not set by the same edge also clears.
REQ-028 r_enable deasserted mid-frame: the frame completes normally; only the next start detection is gated.
REQ-029 Back-to-back frames: a start edge arriving immediately after the stop bit is detected, because IDLE is re-entered at the stop mid-bit.

Reset
REQ-030 reset=1 at any edge, including mid-frame: state IDLE, counters 0, shift register 0, both synchronizer flops 1, data_out=0, data_valid=0, char_received=0, frame_err=0, overrun=0, busy=0.
REQ-031 The first edge after reset release behaves as IDLE with a high line; a partial frame in progress at reset is discarded.

Verification
REQ-032 Send 0xA5 (line 0,1,0,1,0,0,1,0,1,1 at 16 clk/bit), r_enable=1 -> data_out=0xA5, data_valid=1, one char_received pulse 153 cycles after sync_rx falls (+2 from the pin), frame_err=0.
REQ-033 Low glitch of 4 cycles on serial_in -> back to IDLE at sample 7, no outputs change, busy high for 8 cycles.
REQ-034 Send 0x3C with stop bit 0, holding the line low 40 more cycles -> frame_err=1, data_valid unchanged, state WAIT_IDLE until the line rises, no false restart.
REQ-035 Send 0x11 then 0x22 back-to-back, no read_ack -> data_out=0x22, overrun=1; then read_ack -> data_valid=0, overrun=0.
REQ-036 Assert reset during data bit 4 of 0x5A, release, then send 0x81 -> only 0x81 is received; all outputs are 0 during reset.
REQ-037 Pulse read_ack on the exact edge the second of two characters (0x01, 0x02) completes -> data_out=0x02, data_valid=1, overrun=0.
